// File: rtl/sr_flag_bank_pkg.sv
// Shared constants for the UART status flag bank: priority modes and the
// channel map used to build EDGE_MASK and decode status bits.
package sr_flag_bank_pkg;

   localparam logic SR_SET_DOM = 1'b1;
   localparam logic SR_CLR_DOM = 1'b0;

   localparam int RX_READY   = 0;
   localparam int TX_EMPTY   = 1;
   localparam int FRAME_ERR  = 2;
   localparam int PARITY_ERR = 3;
   localparam int RX_OVERRUN = 4;

   // One-hot helper so an EDGE_MASK can be written as chan_bit(A) | chan_bit(B).
   function automatic logic [31:0] chan_bit(input int idx);
      logic [31:0] one_hot;
      one_hot = '0;
      one_hot[idx] = 1'b1;
      return one_hot;
   endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One status channel: level/edge set detection, SR flag with selectable
// priority, and a sticky overrun bit.
module sr_flag_cell
   import sr_flag_bank_pkg::*;
#(
   parameter bit EDGE_MODE    = 1'b0,
   parameter bit SET_PRIORITY = SR_SET_DOM
) (
   input  logic clk,
   input  logic rst_s,
   input  logic set,
   input  logic clr,
   output logic flag,
   output logic ovr
);

   logic set_q;
   logic evt;

   always_comb begin
      evt = EDGE_MODE ? (set & ~set_q) : set;
   end

   // Overrun looks at the flag before this edge; a clear always wins for ovr.
   always_ff @(posedge clk or posedge rst_s) begin
      if (rst_s) begin
         set_q <= 1'b0;
         flag  <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         set_q <= set;
         if (evt && clr)
            flag <= SET_PRIORITY;
         else if (evt)
            flag <= 1'b1;
         else if (clr)
            flag <= 1'b0;
         if (clr)
            ovr <= 1'b0;
         else if (evt && flag)
            ovr <= 1'b1;
      end
   end

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of N set/reset status flags with W1C clear, interrupt mask and a
// registered interrupt output for the UART status path.
module sr_flag_bank
   import sr_flag_bank_pkg::*;
#(
   parameter int           N            = 8,
   parameter bit           SET_PRIORITY = SR_SET_DOM,
   parameter logic [N-1:0] EDGE_MASK    = {N{1'b0}}
) (
   input  logic         clk,
   input  logic         rst_s,
   input  logic [N-1:0] set,
   input  logic         clr_we,
   input  logic [N-1:0] clr_data,
   input  logic         mask_we,
   input  logic [N-1:0] mask_data,
   output logic [N-1:0] flags,
   output logic [N-1:0] ovr,
   output logic [N-1:0] mask,
   output logic         irq
);

   logic [N-1:0] clr;

   always_comb begin
      clr = {N{clr_we}} & clr_data;
   end

   for (genvar i = 0; i < N; i++) begin : g_cell
      sr_flag_cell #(
         .EDGE_MODE    (EDGE_MASK[i]),
         .SET_PRIORITY (SET_PRIORITY)
      ) u_cell (
         .clk   (clk),
         .rst_s (rst_s),
         .set   (set[i]),
         .clr   (clr[i]),
         .flag  (flags[i]),
         .ovr   (ovr[i])
      );
   end

   // irq is taken from the registered flags and mask, giving one extra cycle of latency.
   always_ff @(posedge clk or posedge rst_s) begin
      if (rst_s) begin
         mask <= '0;
         irq  <= 1'b0;
      end else begin
         if (mask_we)
            mask <= mask_data;
         irq <= |(flags & mask);
      end
   end

endmodule
